pipelined_cla_adder: RTL

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/cla_pkg.sv | 11 +
 rtl/cla_group.sv | 43 ++++
 rtl/pipelined_cla_adder.sv | 106 ++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// No logic; the pipeline depth is derived from operand width and group size.
// No flow control here.
package cla_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int GROUP_DEF = 4;

    function automatic int cla_nstg(input int width, input int group);
        return width / group;
    endfunction
endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead slice with generate/propagate expansion per bit.
// Latency: purely combinational.
// Backpressure: none, the caller's registers decide when results are captured.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = GROUP_DEF
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             prod;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of products: g[j] gated by all propagates above j.
    always_comb begin
        c    = '0;
        prod = 1'b1;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            prod     = 1'b1;
            c[i + 1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                c[i + 1] = c[i + 1] | (g[j] & prod);
                prod     = prod & p[j];
            end
            c[i + 1] = c[i + 1] | (prod & cin);
        end
    end

    assign s    = p ^ c[GROUP-1:0];
    assign cout = c[GROUP];
    assign cmsb = c[GROUP-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Add/subtract pipeline resolving one lookahead group per stage, operands skewed alongside.
// Latency: WIDTH/GROUP cycles from accepted input to out_valid; one result per cycle.
// Backpressure: single advance enable (~out_valid | out_ready) freezes every stage at once.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GROUP = GROUP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c4,
    output logic             ovf
);
    localparam int NSTG = cla_nstg(WIDTH, GROUP);
    localparam int NPQ  = (NSTG > 1) ? NSTG - 1 : 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             cy;
    } stg_t;

    logic adv;
    stg_t st_q  [NPQ];
    logic vld_q [NPQ];

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] ain, bin, sin, snew;
        logic             cin, vin;
        logic [GROUP-1:0] gs;
        logic             gc, gm;

        // B is inverted once on entry, so later stages see an ordinary add.
        if (k == 0) begin : g_src
            assign ain = a;
            assign bin = sub ? ~b : b;
            assign sin = '0;
            assign cin = sub ? 1'b1 : c0;
            assign vin = in_valid;
        end else begin : g_src
            assign ain = st_q[k-1].a;
            assign bin = st_q[k-1].b;
            assign sin = st_q[k-1].s;
            assign cin = st_q[k-1].cy;
            assign vin = vld_q[k-1];
        end

        cla_group #(.GROUP(GROUP)) u_grp (
            .a    (ain[k*GROUP +: GROUP]),
            .b    (bin[k*GROUP +: GROUP]),
            .cin  (cin),
            .s    (gs),
            .cout (gc),
            .cmsb (gm)
        );

        always_comb begin
            snew                   = sin;
            snew[k*GROUP +: GROUP] = gs;
        end

        if (k < NSTG - 1) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q[k] <= 1'b0;
                end else if (adv) begin
                    vld_q[k] <= vin;
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    st_q[k] <= '{a: ain, b: bin, s: snew, cy: gc};
                end
            end
        end else begin : g_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    s         <= '0;
                    c4        <= 1'b0;
                    ovf       <= 1'b0;
                end else if (adv) begin
                    out_valid <= vin;
                    s         <= snew;
                    c4        <= gc;
                    ovf       <= gc ^ gm;
                end
            end
        end
    end
endmodule
